// File: rtl/pc_pkg.sv
// Shared encodings for the miniLA program-counter/fetch sequencer:
// next-PC selectors, FSM states and the default boot address.
package pc_pkg;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_JIRL = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1C00_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer
// (master) and the instruction memory (slave).
interface pc_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_ack,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_ack,
    output inst_rdata
  );
endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection; 'taken' flags a redirect away from pc+4
// caused by a taken branch, jump or JIRL.
module npc_calc
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_flag,
  input  logic [31:0] imm,
  input  logic [31:0] rj_val,
  output logic [31:0] npc,
  output logic        taken
);

  logic [31:0] seq_pc;
  logic [31:0] rel_pc;
  logic        redirect;

  assign seq_pc = pc + 32'd4;
  assign rel_pc = pc + imm;

  always_comb begin
    npc      = seq_pc;
    redirect = 1'b0;
    case (npc_op)
      NPC_SEQ: begin
        npc      = seq_pc;
        redirect = 1'b0;
      end
      NPC_BR: begin
        npc      = br_flag ? rel_pc : seq_pc;
        redirect = br_flag;
      end
      NPC_JMP: begin
        npc      = rel_pc;
        redirect = 1'b1;
      end
      default: begin
        npc      = rj_val + imm;
        redirect = 1'b1;
      end
    endcase
  end

  // A redirect that happens to land on pc+4 is not counted as taken.
  assign taken = redirect && (npc != seq_pc);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch/execute sequencer for the single-cycle miniLA core.
// Performance counters are built only when PC_PERF_CNT_EN is defined.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_fetch_ctrl_if.master        imem,
  output logic [31:0]            inst,
  output logic                   inst_valid,
  input  logic                   commit,
  input  logic [1:0]             npc_op,
  input  logic                   br_flag,
  input  logic [31:0]            imm,
  input  logic [31:0]            rj_val,
  output logic [31:0]            pc,
  output logic [31:0]            pc4,
  output logic                   misalign_err,
  output logic [31:0]            cnt_retired,
  output logic [31:0]            cnt_taken
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [31:0] npc;
  logic        taken;
  logic        accept;

  npc_calc u_npc_calc (
    .pc      (pc_q),
    .npc_op  (npc_op),
    .br_flag (br_flag),
    .imm     (imm),
    .rj_val  (rj_val),
    .npc     (npc),
    .taken   (taken)
  );

  assign accept = (state_q == S_EXEC) && commit && is_word_aligned(npc);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (imem.inst_ack) begin
          inst_d  = imem.inst_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (commit) begin
          if (is_word_aligned(npc)) begin
            pc_d    = npc;
            state_d = S_FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // Request/valid depend on state alone so memory latency never loops back.
  assign imem.inst_req  = (state_q == S_FETCH);
  assign imem.inst_addr = pc_q;
  assign inst_valid     = (state_q == S_EXEC);
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign pc4            = pc_q + 32'd4;
  assign misalign_err   = err_q;

`ifdef PC_PERF_CNT_EN
  logic [31:0] cnt_retired_q, cnt_retired_d;
  logic [31:0] cnt_taken_q, cnt_taken_d;

  always_comb begin
    cnt_retired_d = cnt_retired_q;
    cnt_taken_d   = cnt_taken_q;
    if (accept) begin
      cnt_retired_d = cnt_retired_q + 32'd1;
      if (taken) cnt_taken_d = cnt_taken_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_retired_q <= 32'd0;
      cnt_taken_q   <= 32'd0;
    end else begin
      cnt_retired_q <= cnt_retired_d;
      cnt_taken_q   <= cnt_taken_d;
    end
  end

  assign cnt_retired = cnt_retired_q;
  assign cnt_taken   = cnt_taken_q;
`else
  logic unused_perf;
  assign unused_perf = accept ^ taken;
  assign cnt_retired = 32'd0;
  assign cnt_taken   = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed table, corner sequences and
// randomized commits against a PC/counter reference model.
module tb_pc_fetch_ctrl;
  import pc_pkg::*;

  localparam logic [31:0] RPC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid;
  logic        commit;
  logic [1:0]  npc_op;
  logic        br_flag;
  logic [31:0] imm;
  logic [31:0] rj_val;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign_err;
  logic [31:0] cnt_retired;
  logic [31:0] cnt_taken;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_ret;
  logic [31:0] m_tkn;

  pc_fetch_ctrl_if imem();

  pc_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .commit       (commit),
    .npc_op       (npc_op),
    .br_flag      (br_flag),
    .imm          (imm),
    .rj_val       (rj_val),
    .pc           (pc),
    .pc4          (pc4),
    .misalign_err (misalign_err),
    .cnt_retired  (cnt_retired),
    .cnt_taken    (cnt_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [1:0] op,
                                          input logic f, input logic [31:0] im,
                                          input logic [31:0] rj);
    case (op)
      2'd0:    return p + 4;
      2'd1:    return f ? p + im : p + 4;
      2'd2:    return p + im;
      default: return rj + im;
    endcase
  endfunction

  task automatic check_counters(input string tag);
`ifdef PC_PERF_CNT_EN
    chk({tag, ".cnt_retired"}, cnt_retired, m_ret);
    chk({tag, ".cnt_taken"}, cnt_taken, m_tkn);
`else
    chk({tag, ".cnt_retired"}, cnt_retired, 32'd0);
    chk({tag, ".cnt_taken"}, cnt_taken, 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem.inst_ack = 1'b0;
    commit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = RPC; m_err = 1'b0; m_ret = 0; m_tkn = 0;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] word, input logic verbose);
    int n = 0;
    while (!imem.inst_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch.req", {31'd0, imem.inst_req}, 32'd1);
    chk("fetch.addr", imem.inst_addr, m_pc);
    imem.inst_rdata = word;
    imem.inst_ack   = 1'b1;
    @(negedge clk);
    imem.inst_ack   = 1'b0;
    if (verbose) begin
      chk("fetch.inst", inst, word);
      chk("fetch.valid", {31'd0, inst_valid}, 32'd1);
      chk("fetch.req_low", {31'd0, imem.inst_req}, 32'd0);
    end
    $display("fetch addr=%08h word=%08h inst=%08h", m_pc, word, inst);
  endtask

  task automatic do_commit(input logic [1:0] op, input logic f, input logic [31:0] im,
                           input logic [31:0] rj, input string tag);
    logic [31:0] nx;
    nx = ref_npc(m_pc, op, f, im, rj);
    npc_op = op; br_flag = f; imm = im; rj_val = rj;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    npc_op = $urandom; br_flag = $urandom; imm = $urandom; rj_val = $urandom;
    if (nx[1:0] == 2'b00) begin
      if (nx != m_pc + 32'd4) m_tkn = m_tkn + 1;
      m_ret = m_ret + 1;
      m_pc  = nx;
    end else begin
      m_err = 1'b1;
    end
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc4"}, pc4, m_pc + 32'd4);
    chk({tag, ".err"}, {31'd0, misalign_err}, {31'd0, m_err});
    chk({tag, ".req"}, {31'd0, imem.inst_req}, {31'd0, ~m_err});
    check_counters(tag);
    $display("commit op=%0d f=%0b imm=%08h rj=%08h -> pc=%08h err=%0b", op, f, im, rj, pc, misalign_err);
  endtask

  typedef struct {
    logic [31:0] setup_pc;
    logic [1:0]  op;
    logic        f;
    logic [31:0] im;
    logic [31:0] rj;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h1C00_0000, 2'd0, 1'b0, 32'h0000_0000, 32'h0,         32'h1C00_0004};
    vecs[1] = '{32'h1C00_0010, 2'd1, 1'b1, 32'hFFFF_FFF8, 32'h0,         32'h1C00_0008};
    vecs[2] = '{32'h1C00_0010, 2'd1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h1C00_0014};
    vecs[3] = '{32'hFFFF_FFFC, 2'd0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000};
    vecs[4] = '{32'h1C00_0100, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'h1C00_0140};
    vecs[5] = '{32'h1C00_0000, 2'd3, 1'b0, 32'h0000_0008, 32'h1C00_0200, 32'h1C00_0208};
    vecs[6] = '{32'h0000_0000, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC};

    rst = 1'b1; commit = 1'b0; npc_op = 0; br_flag = 0; imm = 0; rj_val = 0;
    imem.inst_ack = 1'b0; imem.inst_rdata = 0;
    m_pc = RPC; m_err = 0; m_ret = 0; m_tkn = 0;

    // reset / boot
    @(negedge clk); @(negedge clk);
    chk("rst.pc", pc, RPC);
    chk("rst.inst", inst, 32'd0);
    chk("rst.req", {31'd0, imem.inst_req}, 32'd0);
    chk("rst.valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.err", {31'd0, misalign_err}, 32'd0);
    check_counters("rst");
    rst = 1'b0;
    #1;
    chk("boot.req", {31'd0, imem.inst_req}, 32'd0);
    @(negedge clk);
    chk("boot2fetch.req", {31'd0, imem.inst_req}, 32'd1);
    chk("boot2fetch.addr", imem.inst_addr, RPC);

    // sequential fetch
    fetch(32'h0280_0421, 1'b1);
    do_commit(NPC_SEQ, 1'b0, 32'h0, 32'h0, "seq");

    // directed table; each vector first steers pc with an aligned JIRL
    for (int i = 0; i < 7; i++) begin
      fetch(32'h1000_0000 + i, 1'b0);
      do_commit(NPC_JIRL, 1'b0, 32'h0, vecs[i].setup_pc, "setup");
      fetch(32'h2000_0000 + i, 1'b0);
      do_commit(vecs[i].op, vecs[i].f, vecs[i].im, vecs[i].rj, "vec");
      chk("vec.exp_pc", pc, vecs[i].exp_pc);
    end

    // stray commit in fetch, stray ack in exec
    commit = 1'b1; npc_op = NPC_JMP; imm = 32'h100;
    @(negedge clk);
    commit = 1'b0;
    chk("stray_commit.pc", pc, m_pc);
    chk("stray_commit.req", {31'd0, imem.inst_req}, 32'd1);
    chk("stray_commit.valid", {31'd0, inst_valid}, 32'd0);
    fetch(32'hAAAA_5554, 1'b1);
    imem.inst_rdata = 32'h1234_5678; imem.inst_ack = 1'b1;
    @(negedge clk);
    imem.inst_ack = 1'b0;
    chk("stray_ack.inst", inst, 32'hAAAA_5554);
    chk("stray_ack.valid", {31'd0, inst_valid}, 32'd1);
    chk("stray_ack.pc", pc, m_pc);
    do_commit(NPC_SEQ, 1'b0, 32'h0, 32'h0, "after_stray");

    // JIRL misaligned -> halt
    fetch(32'h4C00_0000, 1'b0);
    do_commit(NPC_JIRL, 1'b0, 32'h0, 32'h1C00_0102, "misalign");
    repeat (3) @(negedge clk);
    imem.inst_ack = 1'b1; commit = 1'b1;
    @(negedge clk);
    imem.inst_ack = 1'b0; commit = 1'b0;
    chk("halt.req", {31'd0, imem.inst_req}, 32'd0);
    chk("halt.valid", {31'd0, inst_valid}, 32'd0);
    chk("halt.pc", pc, m_pc);
    chk("halt.err", {31'd0, misalign_err}, 32'd1);
    do_reset();

    // async reset mid-fetch with pending ack
    fetch(32'h0280_0421, 1'b0);
    do_commit(NPC_JMP, 1'b0, 32'h40, 32'h0, "pre_arst");
    imem.inst_rdata = 32'hDEAD_BEEC; imem.inst_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst.req", {31'd0, imem.inst_req}, 32'd0);
    chk("arst.valid", {31'd0, inst_valid}, 32'd0);
    chk("arst.pc", pc, RPC);
    chk("arst.inst", inst, 32'd0);
    check_counters("arst_pre");
    @(negedge clk);
    rst = 1'b0;
    m_pc = RPC; m_err = 0; m_ret = 0; m_tkn = 0;
    @(negedge clk);
    imem.inst_ack = 1'b0;
    chk("arst.late_ack_inst", inst, 32'd0);
    chk("arst.late_ack_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst.fetch_req", {31'd0, imem.inst_req}, 32'd1);
    check_counters("arst");

    // randomized commits against the model
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  op;
      logic [31:0] im;
      logic [31:0] rj;
      op = 2'($urandom_range(0, 3));
      im = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 3) == 0) im = {{20{im[11]}}, im[11:0]};
      rj = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 39) == 0) im[1] = 1'b1;
      fetch($urandom, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_commit(op, 1'($urandom_range(0, 1)), im, rj, "rand");
      if (m_err) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch sequencer for the single-cycle miniLA core.
- Holds the architectural PC and issues one instruction-memory request per instruction.
- Presents the fetched instruction to decode/execute and waits for the commit pulse.
- On commit, loads the next PC from the `npc_op` selection, the ALU branch flag `f` (arriving here as `br_flag`) and the decoded immediate.
- Sits directly downstream of the ALU flag output and upstream of decode.

## Interface
Parameters:
- `RESET_PC`, default 32'h1C00_0000: PC value loaded on reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `inst_req`, out, 1: fetch request to instruction memory.
- `inst_addr`, out, 32: fetch address, always equal to `pc`.
- `inst_ack`, in, 1: instruction memory has `inst_rdata` valid this cycle.
- `inst_rdata`, in, 32: instruction word from memory.
- `inst`, out, 32: latched instruction for decode.
- `inst_valid`, out, 1: `inst` is valid and executing.
- `commit`, in, 1: execute/writeback of the current instruction completes this cycle.
- `npc_op`, in, 2: next-PC select, where 0 = SEQ, 1 = BR_COND, 2 = JUMP (B/BL), 3 = JIRL.
- `br_flag`, in, 1: branch condition from the ALU flag.
- `imm`, in, 32: sign-extended, pre-shifted (<<2) offset.
- `rj_val`, in, 32: register rj value, used for JIRL.
- `pc`, out, 32: current PC.
- `pc4`, out, 32: `pc + 4`, the link value for BL/JIRL.
- `misalign_err`, out, 1: sticky error flag for a misaligned next PC.
- `cnt_retired`, out, 32: performance counter for committed instructions (see Configuration).
- `cnt_taken`, out, 32: performance counter for taken branches or jumps (see Configuration).

## Operation
States are S_BOOT, S_FETCH, S_EXEC and S_HALT.

- **S_BOOT**
  - Entered from reset; lasts one cycle.
  - All request and valid outputs are 0.
  - Transitions to S_FETCH.
- **S_FETCH**
  - `inst_req` = 1 and `inst_addr` = `pc`.
  - On `inst_ack`: latch `inst_rdata` into `inst`, then go to S_EXEC.
  - No timeout; the block waits indefinitely for `inst_ack`.
- **S_EXEC**
  - `inst_valid` = 1 and `inst_req` = 0.
  - On `commit`, compute the next PC `npc`:
    - SEQ: `pc + 4`.
    - BR_COND: `pc + imm` if `br_flag`, else `pc + 4`.
    - JUMP: `pc + imm`.
    - JIRL: `rj_val + imm`.
  - If `npc[1:0]` == 0, load `pc` = `npc` and go to S_FETCH.
  - Otherwise, leave `pc` unchanged, set `misalign_err` = 1 and go to S_HALT.
- **S_HALT**
  - Terminal state; only `rst` exits it.
  - `inst_req` = 0 and `inst_valid` = 0.

Arithmetic rules:
- All adds are 32-bit and wrap modulo 2^32, e.g. `pc` = FFFF_FFFC with SEQ gives 0000_0000.
- `pc4` is computed combinationally from `pc`.

Ignored inputs:
- `inst_ack` is ignored outside S_FETCH.
- `commit` is ignored outside S_EXEC.
- `npc_op`, `br_flag`, `imm` and `rj_val` are sampled only on the commit edge.

Reset values:
- `pc` = `RESET_PC` and `inst` = 0.
- `inst_req`, `inst_valid` and `misalign_err` = 0.
- Counters = 0.
- Reset mid-fetch drops the outstanding request; a late `inst_ack` after reset is ignored while in S_BOOT.

## Timing
- `inst_ack` is sampled at edge N. `inst`/`inst_valid` are visible after edge N.
- `commit` can be asserted in the first S_EXEC cycle.
- `commit` at edge M updates `pc` after M, and `inst_req` for the new PC is high in the cycle after M.
- Minimum throughput is 2 cycles per instruction (ack cycle plus commit cycle).
- `inst_req` is combinational from state only, not from `inst_ack`.

## Configuration
Macro: `PC_PERF_CNT_EN`.
- **Defined:**
  - `cnt_retired` increments on every accepted commit (one that leads to S_FETCH). A misaligned commit does not count.
  - `cnt_taken` increments when the committed `npc` != `pc + 4` for a BR_COND taken, JUMP or JIRL.
  - Both counters wrap at 2^32.
- **Undefined:** ports remain present and are tied to 0; no counter flops are built.

## Structure
- Package `pc_pkg` holds:
  - the `npc_op` encodings `NPC_SEQ`/`NPC_BR`/`NPC_JMP`/`NPC_JIRL`;
  - the state enum;
  - the default `RESET_PC`.
- One combinational sub-module, `npc_calc`:
  - inputs: `pc`, `npc_op`, `br_flag`, `imm`, `rj_val`;
  - outputs: `npc` and `taken`.
- The FSM, PC register and counters live in `pc_fetch_ctrl`.

## Test plan
- **Reset/boot:** release `rst`. Expect `pc` = 1C00_0000, `inst_req` = 0 for one cycle, then 1 with `inst_addr` = 1C00_0000.
- **Sequential fetch:**
  - Stimulus: ack with 0280_0421, then commit with SEQ.
  - Expect `inst` = 0280_0421 and `inst_valid` = 1, then `pc` = 1C00_0004.
  - With `PC_PERF_CNT_EN`: `cnt_retired` = 1 and `cnt_taken` = 0.
- **Conditional branch:**
  - At `pc` = 1C00_0010, BR_COND with `imm` = FFFF_FFF8.
  - `br_flag` = 1 gives `pc` = 1C00_0008; `br_flag` = 0 gives 1C00_0014.
- **JIRL misaligned:** `rj_val` = 1C00_0102 with `imm` = 0. Expect `misalign_err` = 1, `pc` unchanged, `inst_req` stays 0 until `rst`.
- **Wrap and stray inputs:**
  - `pc` = FFFF_FFFC with SEQ gives `pc` = 0.
  - `commit` pulsed during S_FETCH and `inst_ack` pulsed during S_EXEC both have no effect.
- **Async reset mid-fetch:** assert `rst` while `inst_req` = 1 and `inst_ack` is pending. Outputs clear immediately without a clock edge, and the ack in the first post-reset cycle is ignored.
